lifo_arbiter: RTL and testbench

//  Shares one LIFO (single wr/rd port, flags full/empty) between N_CLIENTS requesters.

---
 rtl/lifo_arbiter_pkg.sv | 15 +
 rtl/lifo_arbiter_rr.sv | 33 +++
 rtl/lifo_arbiter.sv | 116 +++++++++++
 tb/tb_lifo_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arbiter_pkg.sv
// Shared types, limits and helpers for the LIFO arbiter.
// The FSM encoding, client/latency limits and round-robin pointer advance live here.
package lifo_arb_pkg;

    typedef enum logic [1:0] {ST_ARB, ST_FLUSH, ST_DONE} lifo_arb_state_t;

    localparam int MAX_CLIENTS    = 16;
    localparam int MAX_RD_LATENCY = 4;

    // Explicit compare keeps wrap correct for non-power-of-2 client counts.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/lifo_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_grant
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_grant && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one single-port LIFO among N_CLIENTS push/pop requesters, routes pop
// data back through a read-latency pipe, and drains the LIFO on flush command.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int N_CLIENTS  = 4,
    parameter int DWIDTH     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic [N_CLIENTS-1:0]        req_valid,
    input  logic [N_CLIENTS-1:0]        req_pop,
    input  logic [N_CLIENTS*DWIDTH-1:0] req_data,
    output logic [N_CLIENTS-1:0]        req_ready,
    output logic [N_CLIENTS-1:0]        resp_valid,
    output logic [DWIDTH-1:0]           resp_data,
    input  logic                        flush_req,
    output logic                        flush_busy,
    output logic                        flush_done,
    output logic [DWIDTH-1:0]           lifo_data,
    output logic                        lifo_wrreq,
    output logic                        lifo_rdreq,
    input  logic [DWIDTH-1:0]           lifo_q,
    input  logic                        lifo_empty,
    input  logic                        lifo_full
);

    localparam int ID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    lifo_arb_state_t       state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  flush_busy_q, flush_done_q;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]       pipe_id_q [RD_LATENCY];
    logic [ID_W-1:0]       pipe_id_d [RD_LATENCY];

    logic [N_CLIENTS-1:0]  eligible, elig_gated, grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  any_grant, grant_pop, arb_en, pipe_busy;

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            eligible[i] = req_valid[i] & (req_pop[i] ? !lifo_empty : !lifo_full);
        end
    end

    // A flush request wins over any grant in the cycle it is seen.
    assign arb_en     = (state_q == ST_ARB) && !flush_req && !srst;
    assign elig_gated = arb_en ? eligible : '0;

    rr_arbiter #(.N(N_CLIENTS), .ID_W(ID_W)) u_rr (
        .eligible  (elig_gated),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign grant_pop  = any_grant && req_pop[grant_idx];
    assign req_ready  = grant;
    assign lifo_wrreq = any_grant && !req_pop[grant_idx];
    assign lifo_data  = lifo_wrreq ? req_data[int'(grant_idx)*DWIDTH +: DWIDTH] : '0;
    assign lifo_rdreq = grant_pop || ((state_q == ST_FLUSH) && !lifo_empty && !srst);
    assign pipe_busy  = |pipe_vld_q;
    assign flush_busy = flush_busy_q;
    assign flush_done = flush_done_q;

    always_comb begin
        ptr_d = any_grant ? ID_W'(rr_next(int'(grant_idx), N_CLIENTS)) : ptr_q;
        pipe_vld_d[0] = grant_pop;
        pipe_id_d[0]  = grant_idx;
        for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_id_d[k]  = pipe_id_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (flush_req) state_d = ST_FLUSH;
            ST_FLUSH: if (lifo_empty && !pipe_busy) state_d = ST_DONE;
            ST_DONE:  state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // Drain reads enter the pipe with valid=0, so only real pops return data.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            resp_valid[pipe_id_q[RD_LATENCY-1]] = 1'b1;
            resp_data = lifo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_ARB;
            ptr_q        <= '0;
            pipe_vld_q   <= '0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pipe_vld_q   <= pipe_vld_d;
            flush_busy_q <= (state_d != ST_ARB);
            flush_done_q <= (state_d == ST_DONE);
        end
        pipe_id_q <= pipe_id_d;
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a small behavioural LIFO (depth 8,
// read latency 3) attached to the LIFO-side ports.
module tb_lifo_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int RL = 3;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            srst;
    logic [N-1:0]    req_valid, req_pop, req_ready, resp_valid;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   resp_data, lifo_data, lifo_q;
    logic            flush_req, flush_busy, flush_done;
    logic            lifo_wrreq, lifo_rdreq, lifo_empty, lifo_full;
    logic            force_full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lifo_arbiter #(.N_CLIENTS(N), .DWIDTH(DW), .RD_LATENCY(RL)) dut (
        .clk        (clk),
        .srst       (srst),
        .req_valid  (req_valid),
        .req_pop    (req_pop),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .lifo_data  (lifo_data),
        .lifo_wrreq (lifo_wrreq),
        .lifo_rdreq (lifo_rdreq),
        .lifo_q     (lifo_q),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full)
    );

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdpipe [RL];
    int cnt;

    assign lifo_empty = (cnt == 0);
    assign lifo_full  = (cnt == DEPTH) || force_full;
    assign lifo_q     = rdpipe[RL-1];

    always @(posedge clk) begin
        if (srst) begin
            cnt <= 0;
        end else if (lifo_wrreq && cnt < DEPTH) begin
            mem[cnt] <= lifo_data;
            cnt <= cnt + 1;
        end else if (lifo_rdreq && cnt > 0) begin
            cnt <= cnt - 1;
        end
        rdpipe[0] <= (!srst && lifo_rdreq && cnt > 0) ? mem[cnt-1] : '0;
        for (int k = 1; k < RL; k++) rdpipe[k] <= rdpipe[k-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    initial begin
        srst = 1'b1; req_valid = 4'hF; req_pop = 4'h0; flush_req = 1'b0; force_full = 1'b0;
        for (int i = 0; i < N; i++) set_data(i, DW'(16'h1000 + i));

        // Reset with every client requesting
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wrreq", 32'(lifo_wrreq), 32'h0);
        chk("rst_rdreq", 32'(lifo_rdreq), 32'h0);
        chk("rst_lifo_data", 32'(lifo_data), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_busy", 32'(flush_busy), 32'h0);
        chk("rst_done", 32'(flush_done), 32'h0);
        srst = 1'b0;

        // Fairness: all push, grants rotate from client 0
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            chk($sformatf("rr_wrreq_%0d", k), 32'(lifo_wrreq), 32'h1);
            chk($sformatf("rr_data_%0d", k), 32'(lifo_data), 32'h1000 + 32'(k % 4));
            tick();
        end

        // Flush of 5 entries with all clients still requesting
        flush_req = 1'b1; #1;
        chk("f0_ready", 32'(req_ready), 32'h0);
        chk("f0_wrreq", 32'(lifo_wrreq), 32'h0);
        chk("f0_busy", 32'(flush_busy), 32'h0);
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("fl_rdreq_%0d", k), 32'(lifo_rdreq), 32'h1);
            chk($sformatf("fl_ready_%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("fl_resp_%0d", k), 32'(resp_valid), 32'h0);
            chk($sformatf("fl_busy_%0d", k), 32'(flush_busy), 32'h1);
            chk($sformatf("fl_done_%0d", k), 32'(flush_done), 32'h0);
            tick();
        end
        #1;
        chk("f6_rdreq", 32'(lifo_rdreq), 32'h0);
        chk("f6_done", 32'(flush_done), 32'h0);
        chk("f6_resp", 32'(resp_valid), 32'h0);
        tick(); #1;
        chk("f7_done", 32'(flush_done), 32'h1);
        chk("f7_ready", 32'(req_ready), 32'h0);
        chk("f7_busy", 32'(flush_busy), 32'h1);
        tick(); #1;
        chk("f8_ready", 32'(req_ready), 32'h2);
        chk("f8_data", 32'(lifo_data), 32'h1001);
        chk("f8_busy", 32'(flush_busy), 32'h0);
        chk("f8_done", 32'(flush_done), 32'h0);
        tick();

        // Routing: client 2 pushes A5A5, client 1 pops it
        req_valid = 4'b0100; set_data(2, 16'hA5A5); #1;
        chk("r0_ready", 32'(req_ready), 32'h4);
        chk("r0_data", 32'(lifo_data), 32'hA5A5);
        tick();
        req_valid = 4'b0010; req_pop = 4'b0010; #1;
        chk("r1_ready", 32'(req_ready), 32'h2);
        chk("r1_rdreq", 32'(lifo_rdreq), 32'h1);
        chk("r1_wrreq", 32'(lifo_wrreq), 32'h0);
        chk("r1_lifo_data", 32'(lifo_data), 32'h0);
        tick();
        req_valid = 4'b0; req_pop = 4'b0; #1;
        chk("r2_resp", 32'(resp_valid), 32'h0);
        tick(); #1;
        chk("r3_resp", 32'(resp_valid), 32'h0);
        tick(); #1;
        chk("r4_resp_valid", 32'(resp_valid), 32'h2);
        chk("r4_resp_data", 32'(resp_data), 32'hA5A5);
        tick(); #1;
        chk("r5_resp_valid", 32'(resp_valid), 32'h0);
        chk("r5_resp_data", 32'(resp_data), 32'h0);

        // Boundaries: full stalls client 0 push, client 3 pop proceeds, then empties
        force_full = 1'b1; req_valid = 4'b1001; req_pop = 4'b1000; #1;
        chk("b0_ready", 32'(req_ready), 32'h8);
        chk("b0_rdreq", 32'(lifo_rdreq), 32'h1);
        chk("b0_wrreq", 32'(lifo_wrreq), 32'h0);
        tick(); #1;
        chk("b1_ready", 32'(req_ready), 32'h0);
        chk("b1_wrreq", 32'(lifo_wrreq), 32'h0);
        chk("b1_rdreq", 32'(lifo_rdreq), 32'h0);
        tick();
        req_valid = 4'b0; req_pop = 4'b0; force_full = 1'b0;
        tick(); #1;
        chk("b3_resp_valid", 32'(resp_valid), 32'h8);
        chk("b3_resp_data", 32'(resp_data), 32'h1001);
        tick();

        // Flush with a pop in flight
        req_valid = 4'b0001; set_data(0, 16'h0B0B); #1;
        chk("p0_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010; set_data(1, 16'h1C1C); #1;
        chk("p1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100; req_pop = 4'b0100; #1;
        chk("p2_ready", 32'(req_ready), 32'h4);
        chk("p2_rdreq", 32'(lifo_rdreq), 32'h1);
        tick();
        req_valid = 4'b0; req_pop = 4'b0; flush_req = 1'b1; #1;
        chk("p3_ready", 32'(req_ready), 32'h0);
        tick();
        flush_req = 1'b0; #1;
        chk("p4_rdreq", 32'(lifo_rdreq), 32'h1);
        chk("p4_busy", 32'(flush_busy), 32'h1);
        chk("p4_resp", 32'(resp_valid), 32'h0);
        tick(); #1;
        chk("p5_resp_valid", 32'(resp_valid), 32'h4);
        chk("p5_resp_data", 32'(resp_data), 32'h1C1C);
        chk("p5_rdreq", 32'(lifo_rdreq), 32'h0);
        chk("p5_done", 32'(flush_done), 32'h0);
        tick(); #1;
        chk("p6_done", 32'(flush_done), 32'h0);
        chk("p6_resp", 32'(resp_valid), 32'h0);
        tick(); #1;
        chk("p7_done", 32'(flush_done), 32'h1);
        chk("p7_resp", 32'(resp_valid), 32'h0);
        tick(); #1;
        chk("p8_done", 32'(flush_done), 32'h0);
        chk("p8_busy", 32'(flush_busy), 32'h0);
        tick();

        // Reset in the middle of a flush
        req_valid = 4'b1000; set_data(3, 16'h3333); #1;
        chk("q0_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0001; set_data(0, 16'h4444); #1;
        chk("q1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0; flush_req = 1'b1; #1;
        chk("q2_ready", 32'(req_ready), 32'h0);
        tick();
        flush_req = 1'b0; #1;
        chk("q3_rdreq", 32'(lifo_rdreq), 32'h1);
        chk("q3_busy", 32'(flush_busy), 32'h1);
        tick();
        srst = 1'b1; #1;
        chk("q4_rdreq", 32'(lifo_rdreq), 32'h0);
        chk("q4_ready", 32'(req_ready), 32'h0);
        tick();
        srst = 1'b0; req_valid = 4'b0011; #1;
        chk("q5_busy", 32'(flush_busy), 32'h0);
        chk("q5_done", 32'(flush_done), 32'h0);
        chk("q5_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0; #1;
        chk("q6_done", 32'(flush_done), 32'h0);
        tick(); #1;
        chk("q7_done", 32'(flush_done), 32'h0);
        chk("q7_busy", 32'(flush_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
